spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one SPIMaster engine (2..8).
REQ-002 Parameter GAP_CYCLES, default 2: minimum SS-deasserted cycles between transfers (>=1).
REQ-003 Parameter TIMEOUT, default 1024: maximum XFER cycles before abort.
REQ-004 Port HCLK  in  1  sole clock; all logic on rising edge.
REQ-005 Port HRESETn  in  1  reset, synchronous and active-low.
REQ-006 Port req_valid_i  in  NUM_REQ  per-requester transfer request, held until accepted.
REQ-007 Port req_ready_o  out  NUM_REQ  one-cycle accept pulse to the granted requester.
REQ-008 Port req_ss_idx_i  in  NUM_REQ*5  per-requester slave index 0..31.
REQ-009 Port req_wdata_i  in  NUM_REQ*32  per-requester write word.
REQ-010 Port req_nbytes_i  in  NUM_REQ*3  per-requester byte count, valid 1..4.
REQ-011 Port rsp_valid_o  out  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-012 Port rsp_err_o  out  1  qualifies rsp_valid_o: 1 = timeout or illegal byte count.
REQ-013 Port rsp_rdata_o  out  32  read word captured at completion, held until next completion.
REQ-014 Port spi_enable_o  out  1  SPIMaster enable.
REQ-015 Port spi_wdata_o  out  32  latched write word to SPIMaster.
REQ-016 Port spi_nbytes_o  out  3  latched byte count to SPIMaster.
REQ-017 Port spi_reset_fill_o  out  1  one-cycle SPIMaster fill-level clear.
REQ-018 Port spi_ss_o  out  32  active-low slave selects, at most one bit low.
REQ-019 Port spi_rdata_i  in  32  SPIMaster read data.
REQ-020 Port spi_bytes_valid_i  in  3  SPIMaster count of bytes transferred.

Function
REQ-021 FSM states IDLE, SETUP, XFER, DONE, GAP; all outputs registered.
REQ-022 IDLE: if any req_valid_i set, grant round-robin starting at (last_grant+1) mod NUM_REQ, pulse req_ready_o[grant], latch ss_idx/wdata/nbytes, go SETUP.
REQ-023 IDLE with latched nbytes 0 or >4: still pulse req_ready_o, skip SPI activity, go DONE with rsp_err_o=1.
REQ-024 SETUP (1 cycle): drive spi_ss_o[ss_idx]=0, pulse spi_reset_fill_o, drive spi_wdata_o/spi_nbytes_o, go XFER.
REQ-025 XFER: spi_enable_o=1, SS held; when spi_bytes_valid_i == latched nbytes go DONE with rsp_err_o=0.
REQ-026 XFER timeout: cycle counter reaches TIMEOUT-1 without completion -> go DONE with rsp_err_o=1.
REQ-027 DONE (1 cycle): capture rsp_rdata_o <= spi_rdata_i (unchanged on illegal count), pulse rsp_valid_o[grant], spi_enable_o=0, spi_ss_o=all ones, go GAP.
REQ-028 GAP: hold SS all ones for GAP_CYCLES cycles, then IDLE; requests are not sampled outside IDLE.
REQ-029 Request-to-SS-low latency 2 cycles; completion-to-rsp_valid latency 1 cycle.
REQ-030 last_grant updates only on grant; a lone requester is re-granted after each GAP (no starvation of others with rotating priority).
REQ-031 req_valid_i dropping before grant is legal and withdraws the request.

Reset
REQ-032 HRESETn low at any edge, including mid-XFER: state IDLE, spi_ss_o=32'hFFFF_FFFF, spi_enable_o/spi_reset_fill_o/req_ready_o/rsp_valid_o/rsp_err_o=0, rsp_rdata_o/spi_wdata_o=0, spi_nbytes_o=0, last_grant=NUM_REQ-1 (requester 0 first), counters 0.
REQ-033 No rsp_valid_o is issued for a transfer aborted by reset.

Structure
REQ-034 State encoding, SS-idle constant 32'hFFFF_FFFF and max byte count 4 reside in shared package spi_pkg; SPIMaster instance lives outside this block.
REQ-035 Round-robin priority select is one sub-module rr_arbiter (NUM_REQ parameter, one-hot grant output).

Verification
REQ-036 Req0 ss=3, wdata=32'hA5A5_0F0F, nbytes=2; model reports 2 bytes after 16 cycles -> ready0 at T, ss_o=32'hFFFF_FFF7 at T+2, rsp_valid0 with err=0 and model rdata.
REQ-037 Req0..3 all valid from reset -> grants in order 0,1,2,3, each separated by >=GAP_CYCLES SS-high cycles.
REQ-038 Req2 nbytes=0 -> ready2, rsp_valid2 with err=1, spi_ss_o never leaves all ones.
REQ-039 Model never reaches count, TIMEOUT=64 -> rsp_err_o=1 after 64 XFER cycles, SS released.
REQ-040 HRESETn low mid-XFER -> next cycle spi_ss_o all ones, enable 0, no rsp_valid_o; next request granted to requester 0.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | spi_pkg : shared state encoding and constants for spi_arbiter   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_DONE  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  localparam logic [31:0] SS_IDLE    = 32'hFFFF_FFFF;
  localparam logic [2:0]  MAX_NBYTES = 3'd4;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | rr_arbiter : rotating-priority select, search starts after last |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module rr_arbiter #(
  parameter int  NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [NUM_REQ-1:0] grant_o
);

  int          idx;
  logic [IW-1:0] sel;
  logic        found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(last_i) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = IW'(idx);
      if (!found && req_i[sel]) begin
        grant_o[sel] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | spi_arbiter : shares one SPIMaster engine among NUM_REQ clients |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [NUM_REQ*5-1:0] req_ss_idx_i,
  input  logic [NUM_REQ*32-1:0] req_wdata_i,
  input  logic [NUM_REQ*3-1:0] req_nbytes_i,
  output logic [NUM_REQ-1:0]   rsp_valid_o,
  output logic                 rsp_err_o,
  output logic [31:0]          rsp_rdata_o,
  output logic                 spi_enable_o,
  output logic [31:0]          spi_wdata_o,
  output logic [2:0]           spi_nbytes_o,
  output logic                 spi_reset_fill_o,
  output logic [31:0]          spi_ss_o,
  input  logic [31:0]          spi_rdata_i,
  input  logic [2:0]           spi_bytes_valid_i
);

  localparam int IW   = $clog2(NUM_REQ);
  localparam int CMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  logic [4:0]  w_ss_idx [NUM_REQ];
  logic [31:0] w_wdata  [NUM_REQ];
  logic [2:0]  w_nbytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_ss_idx[g] = req_ss_idx_i[g*5 +: 5];
    assign w_wdata[g]  = req_wdata_i[g*32 +: 32];
    assign w_nbytes[g] = req_nbytes_i[g*3 +: 3];
  end

  state_e              state_q, state_d;
  logic [IW-1:0]       last_q, last_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [4:0]          ss_idx_q, ss_idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          nbytes_q, nbytes_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d, rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d, en_q, en_d, fill_q, fill_d;
  logic [31:0]         rdata_q, rdata_d, spi_wdata_q, spi_wdata_d, ss_q, ss_d;
  logic [2:0]          spi_nbytes_q, spi_nbytes_d;

  logic [NUM_REQ-1:0]  w_grant;
  logic [IW-1:0]       w_gidx;
  logic                w_nb_bad, w_ok, w_to;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i   (req_valid_i),
    .last_i  (last_q),
    .grant_o (w_grant)
  );

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_gidx = IW'(i);
    end
  end

  assign w_nb_bad = (w_nbytes[w_gidx] == 3'd0) || (w_nbytes[w_gidx] > MAX_NBYTES);
  // The first XFER cycle overlaps the fill clear, so a stale count must not end the transfer.
  assign w_ok = !fill_q && (spi_bytes_valid_i == nbytes_q);
  assign w_to = (cnt_q == TO_LAST);

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    grant_d      = grant_q;
    ss_idx_d     = ss_idx_q;
    wdata_d      = wdata_q;
    nbytes_d     = nbytes_q;
    cnt_d        = cnt_q;
    ready_d      = '0;
    rsp_valid_d  = '0;
    rsp_err_d    = 1'b0;
    fill_d       = 1'b0;
    en_d         = en_q;
    rdata_d      = rdata_q;
    spi_wdata_d  = spi_wdata_q;
    spi_nbytes_d = spi_nbytes_q;
    ss_d         = ss_q;
    case (state_q)
      ST_IDLE: begin
        if (|w_grant) begin
          ready_d  = w_grant;
          grant_d  = w_grant;
          last_d   = w_gidx;
          ss_idx_d = w_ss_idx[w_gidx];
          wdata_d  = w_wdata[w_gidx];
          nbytes_d = w_nbytes[w_gidx];
          cnt_d    = '0;
          if (w_nb_bad) begin
            state_d     = ST_DONE;
            rsp_valid_d = w_grant;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        ss_d         = SS_IDLE & ~(32'd1 << ss_idx_q);
        fill_d       = 1'b1;
        spi_wdata_d  = wdata_q;
        spi_nbytes_d = nbytes_q;
        en_d         = 1'b1;
        cnt_d        = '0;
        state_d      = ST_XFER;
      end
      ST_XFER: begin
        if (w_ok || w_to) begin
          state_d     = ST_DONE;
          rsp_valid_d = grant_q;
          rsp_err_d   = !w_ok;
          rdata_d     = spi_rdata_i;
          ss_d        = SS_IDLE;
          en_d        = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      last_q       <= IW'(NUM_REQ - 1);
      grant_q      <= '0;
      ss_idx_q     <= '0;
      wdata_q      <= '0;
      nbytes_q     <= '0;
      cnt_q        <= '0;
      ready_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= 1'b0;
      fill_q       <= 1'b0;
      en_q         <= 1'b0;
      rdata_q      <= '0;
      spi_wdata_q  <= '0;
      spi_nbytes_q <= '0;
      ss_q         <= SS_IDLE;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      ss_idx_q     <= ss_idx_d;
      wdata_q      <= wdata_d;
      nbytes_q     <= nbytes_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      fill_q       <= fill_d;
      en_q         <= en_d;
      rdata_q      <= rdata_d;
      spi_wdata_q  <= spi_wdata_d;
      spi_nbytes_q <= spi_nbytes_d;
      ss_q         <= ss_d;
    end
  end

  assign req_ready_o      = ready_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_err_o        = rsp_err_q;
  assign rsp_rdata_o      = rdata_q;
  assign spi_enable_o     = en_q;
  assign spi_wdata_o      = spi_wdata_q;
  assign spi_nbytes_o     = spi_nbytes_q;
  assign spi_reset_fill_o = fill_q;
  assign spi_ss_o         = ss_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_spi_arbiter : scoreboard bench with a behavioural SPIMaster  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_spi_arbiter;

  localparam int NR  = 4;
  localparam int GAP = 2;
  localparam int TO  = 64;
  localparam logic [31:0] RD_KEY = 32'h5A5A_5A5A;

  logic           HCLK = 1'b0;
  logic           HRESETn;
  logic [NR-1:0]  req_valid_i, req_ready_o, rsp_valid_o;
  logic [NR*5-1:0]  req_ss_idx_i;
  logic [NR*32-1:0] req_wdata_i;
  logic [NR*3-1:0]  req_nbytes_i;
  logic           rsp_err_o, spi_enable_o, spi_reset_fill_o;
  logic [31:0]    rsp_rdata_o, spi_wdata_o, spi_ss_o, spi_rdata_i;
  logic [2:0]     spi_nbytes_o, spi_bytes_valid_i;

  always #5 HCLK = ~HCLK;

  spi_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_ss_idx_i(req_ss_idx_i), .req_wdata_i(req_wdata_i), .req_nbytes_i(req_nbytes_i),
    .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
    .spi_enable_o(spi_enable_o), .spi_wdata_o(spi_wdata_o), .spi_nbytes_o(spi_nbytes_o),
    .spi_reset_fill_o(spi_reset_fill_o), .spi_ss_o(spi_ss_o),
    .spi_rdata_i(spi_rdata_i), .spi_bytes_valid_i(spi_bytes_valid_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural SPIMaster: reports the requested byte count LAT enabled cycles after the fill clear.
  int   cyc = 0;
  int   bv_cyc = 0;
  int   ecnt = 0;
  int   lat = 16;
  bit   hang = 1'b0;
  logic [2:0] bv = 3'd0;
  assign spi_bytes_valid_i = bv;
  assign spi_rdata_i       = spi_wdata_o ^ RD_KEY;

  always @(posedge HCLK) begin
    cyc <= cyc + 1;
    if (!HRESETn || spi_reset_fill_o) begin
      bv   <= 3'd0;
      ecnt <= 0;
    end else if (spi_enable_o) begin
      ecnt <= ecnt + 1;
      if (!hang && (ecnt + 1 == lat)) begin
        bv     <= spi_nbytes_o;
        bv_cyc <= cyc + 1;
      end
    end
  end

  typedef struct { logic [31:0] f_ss; logic [31:0] f_wd; logic [2:0] f_nb; } ss_t;
  typedef struct { int f_idx; logic f_err; logic [31:0] f_rd; } rsp_t;
  int   gr_q[$];
  ss_t  ss_q[$];
  rsp_t rsp_q[$];
  logic [31:0] exp_rd = 32'd0;

  // Monitor: pops expectations whenever the DUT presents a grant, an SS assertion or a response.
  int ready_cyc = 0, ssfall_cyc = 0, rsp_cyc = 0;
  int ss_high_run = 0, ss_low_cnt = 0, en_cnt = 0, gap_n = 0;
  int gaps [64];

  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (req_ready_o != '0) begin
        ready_cyc = cyc;
        if (gr_q.size() == 0) chk("unexpected_ready", 32'(req_ready_o), 32'd0);
        else chk("ready_onehot", 32'(req_ready_o), 32'd1 << gr_q.pop_front());
      end
      if (rsp_valid_o != '0) begin
        rsp_t r;
        rsp_cyc = cyc;
        if (rsp_q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
        else begin
          r = rsp_q.pop_front();
          chk("rsp_onehot", 32'(rsp_valid_o), 32'd1 << r.f_idx);
          chk("rsp_err", 32'(rsp_err_o), 32'(r.f_err));
          chk("rsp_rdata", rsp_rdata_o, r.f_rd);
        end
      end
      if (spi_enable_o) en_cnt++;
    end
    if (spi_ss_o != 32'hFFFF_FFFF) begin
      ss_low_cnt++;
      if (ss_high_run > 0) begin
        ss_t s;
        ssfall_cyc = cyc;
        en_cnt = spi_enable_o ? 1 : 0;
        if (gap_n < 64) gaps[gap_n] = ss_high_run;
        gap_n++;
        if (ss_q.size() == 0) chk("unexpected_ss", spi_ss_o, 32'hFFFF_FFFF);
        else begin
          s = ss_q.pop_front();
          chk("ss_value", spi_ss_o, s.f_ss);
          chk("spi_wdata", spi_wdata_o, s.f_wd);
          chk("spi_nbytes", 32'(spi_nbytes_o), 32'(s.f_nb));
        end
      end
      ss_high_run = 0;
    end else begin
      ss_high_run++;
    end
  end

  task automatic issue(input int i, input logic [4:0] ssi, input logic [31:0] wd,
                       input logic [2:0] nb, input bit to_exp, input bit push_rsp);
    bit bad;
    bad = (nb == 3'd0) || (nb > 3'd4);
    req_ss_idx_i[i*5 +: 5]  = ssi;
    req_wdata_i[i*32 +: 32] = wd;
    req_nbytes_i[i*3 +: 3]  = nb;
    gr_q.push_back(i);
    if (!bad) begin
      ss_q.push_back('{f_ss: ~(32'd1 << ssi), f_wd: wd, f_nb: nb});
      exp_rd = wd ^ RD_KEY;
    end
    if (push_rsp) rsp_q.push_back('{f_idx: i, f_err: bad | to_exp, f_rd: exp_rd});
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge HCLK);
      req_valid_i = req_valid_i & ~req_ready_o;
      n++;
    end while (!(req_valid_i == '0 && rsp_q.size() == 0 && !spi_enable_o) && n < budget);
    chk("idle_wait_in_budget", 32'(n < budget), 32'd1);
    repeat (GAP + 3) @(negedge HCLK);
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    exp_rd  = 32'd0;
  endtask

  initial begin
    int c, g0, l0;
    HRESETn = 1'b0;
    req_valid_i = '0; req_ss_idx_i = '0; req_wdata_i = '0; req_nbytes_i = '0;
    repeat (3) @(negedge HCLK);
    chk("rst_ss", spi_ss_o, 32'hFFFF_FFFF);
    chk("rst_enable", 32'(spi_enable_o), 32'd0);
    chk("rst_fill", 32'(spi_reset_fill_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'd0);
    chk("rst_wdata", spi_wdata_o, 32'd0);
    chk("rst_nbytes", 32'(spi_nbytes_o), 32'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Single transfer: latency of grant, SS assertion and response.
    lat = 16; hang = 1'b0;
    c = cyc;
    issue(0, 5'd3, 32'hA5A5_0F0F, 3'd2, 1'b0, 1'b1);
    req_valid_i[0] = 1'b1;
    run_until_idle(200);
    chk("lat_ready", 32'(ready_cyc), 32'(c + 1));
    chk("lat_ss_low", 32'(ssfall_cyc), 32'(c + 2));
    chk("lat_rsp", 32'(rsp_cyc), 32'(bv_cyc + 1));

    // All four from reset: round-robin order and exact back-to-back SS-high gaps.
    do_reset();
    lat = 4;
    issue(0, 5'd0,  32'h1111_0000, 3'd1, 1'b0, 1'b1);
    issue(1, 5'd9,  32'h2222_0001, 3'd3, 1'b0, 1'b1);
    issue(2, 5'd17, 32'h3333_0002, 3'd4, 1'b0, 1'b1);
    issue(3, 5'd31, 32'h4444_0003, 3'd2, 1'b0, 1'b1);
    g0 = gap_n;
    req_valid_i = 4'hF;
    run_until_idle(400);
    for (int k = 1; k < 4; k++) chk("b2b_ss_gap", 32'(gaps[g0 + k]), 32'(1 + GAP + 2));

    // Illegal byte count: accepted and answered with error, SS untouched.
    l0 = ss_low_cnt;
    issue(2, 5'd5, 32'hDEAD_BEEF, 3'd0, 1'b0, 1'b1);
    req_valid_i[2] = 1'b1;
    run_until_idle(100);
    chk("illegal_ss_low_cycles", 32'(ss_low_cnt - l0), 32'd0);
    issue(3, 5'd6, 32'h0BAD_0BAD, 3'd7, 1'b0, 1'b1);
    req_valid_i[3] = 1'b1;
    run_until_idle(100);

    // Engine never completes: abort after TIMEOUT enabled cycles.
    hang = 1'b1;
    issue(1, 5'd7, 32'hCAFE_F00D, 3'd4, 1'b1, 1'b1);
    req_valid_i[1] = 1'b1;
    run_until_idle(400);
    chk("timeout_enable_cycles", 32'(en_cnt), 32'(TO));
    chk("timeout_ss_released", spi_ss_o, 32'hFFFF_FFFF);

    // Reset mid-transfer: immediate release, no response, priority restarts at 0.
    issue(0, 5'd12, 32'h7777_8888, 3'd2, 1'b0, 1'b0);
    req_valid_i[0] = 1'b1;
    c = 0;
    while (!spi_enable_o && c < 20) begin
      @(negedge HCLK);
      req_valid_i = req_valid_i & ~req_ready_o;
      c++;
    end
    chk("abort_xfer_started", 32'(spi_enable_o), 32'd1);
    repeat (5) @(negedge HCLK);
    HRESETn = 1'b0;
    @(negedge HCLK);
    chk("abort_ss", spi_ss_o, 32'hFFFF_FFFF);
    chk("abort_enable", 32'(spi_enable_o), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid_o), 32'd0);
    HRESETn = 1'b1;
    hang = 1'b0; exp_rd = 32'd0;
    issue(0, 5'd1, 32'h0000_00A0, 3'd1, 1'b0, 1'b1);
    issue(1, 5'd2, 32'h0000_00B1, 3'd2, 1'b0, 1'b1);
    req_valid_i = 4'b0011;
    run_until_idle(400);

    chk("left_grants", 32'(gr_q.size()), 32'd0);
    chk("left_ss", 32'(ss_q.size()), 32'd0);
    chk("left_rsp", 32'(rsp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
